dense_neuron_sequencer: RTL and testbench

Sequences one dense-layer neuron through a `mac_shifter` instance. It streams `IN_COUNT` activations against weights read from a synchronous weight ROM, and seeds the accumulator with a pre-shifted bias. It then presents the final accumulator value on a valid/ready result port. It sits between the layer's activation stream and the next layer or output buffer, one instance per neuron.

---
 rtl/dense_neuron_sequencer_pkg.sv | 10 +
 rtl/dense_neuron_sequencer_if.sv | 31 +++
 rtl/dense_neuron_sequencer_mac_shifter.sv | 34 +++
 rtl/dense_neuron_sequencer.sv | 99 +++++++++
 tb/tb_dense_neuron_sequencer.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/dense_neuron_sequencer_pkg.sv
// Shared types and constants for the dense-layer neuron sequencer.
package dense_seq_pkg;
    localparam int SHIFT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } dense_seq_state_e;
endpackage

// File: rtl/dense_neuron_sequencer_if.sv
// Activation stream, weight ROM, control and result handshake bundle.
// master = upstream/downstream environment, slave = the sequencer.
interface dense_neuron_sequencer_if #(
    parameter int N     = 16,
    parameter int CNT_W = 10
);
    import dense_seq_pkg::*;

    logic                      start_i;
    logic [SHIFT_W-1:0]        shift_i;
    logic signed [2*N-1:0]     bias_i;
    logic                      busy_o;
    logic signed [N-1:0]       data_i;
    logic                      data_valid_i;
    logic                      data_ready_o;
    logic [CNT_W-1:0]          weight_addr_o;
    logic signed [N-1:0]       weight_i;
    logic signed [2*N-1:0]     result_o;
    logic                      result_valid_o;
    logic                      result_ready_i;

    modport master (
        output start_i, shift_i, bias_i, data_i, data_valid_i, weight_i, result_ready_i,
        input  busy_o, data_ready_o, weight_addr_o, result_o, result_valid_o
    );

    modport slave (
        input  start_i, shift_i, bias_i, data_i, data_valid_i, weight_i, result_ready_i,
        output busy_o, data_ready_o, weight_addr_o, result_o, result_valid_o
    );
endinterface

// File: rtl/dense_neuron_sequencer_mac_shifter.sv
// Registered multiply, arithmetic right shift, accumulate; 2N-bit modular sum.
module mac_shifter
    import dense_seq_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic signed [N-1:0]   value_i,
    input  logic signed [N-1:0]   mult_i,
    input  logic [SHIFT_W-1:0]    shift_i,
    input  logic signed [2*N-1:0] add_i,
    output logic signed [2*N-1:0] mac_o
);
    logic signed [2*N-1:0] value_ext;
    logic signed [2*N-1:0] mult_ext;
    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] prod_sh;

    // Explicit sign extension keeps the full-width product signed.
    assign value_ext = {{N{value_i[N-1]}}, value_i};
    assign mult_ext  = {{N{mult_i[N-1]}}, mult_i};
    assign prod      = value_ext * mult_ext;
    assign prod_sh   = prod >>> shift_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mac_o <= '0;
        end else if (en_i) begin
            mac_o <= add_i + prod_sh;
        end
    end
endmodule

// File: rtl/dense_neuron_sequencer.sv
// One dense-layer neuron: streams activations against ROM weights through a MAC.
// Build option DENSE_SEQ_RELU_EN clamps negative results to zero at the output.
//
// state  | meaning
// IDLE   | waiting for start; ROM address parked at 0 to prefetch weight 0
// ACCUM  | accepting activations, one MAC per handshake
// OUTPUT | final accumulator presented until result_ready_i
module dense_neuron_sequencer
    import dense_seq_pkg::*;
#(
    parameter int N        = 16,
    parameter int IN_COUNT = 784,
    parameter int CNT_W    = $clog2(IN_COUNT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dense_neuron_sequencer_if.slave bus
);
    dense_seq_state_e      state;
    dense_seq_state_e      state_nxt;
    logic [CNT_W-1:0]      idx;
    logic [SHIFT_W-1:0]    shift_q;
    logic signed [2*N-1:0] bias_q;
    logic signed [2*N-1:0] mac;
    logic signed [2*N-1:0] mac_add;
    logic signed [2*N-1:0] out_val;
    logic                  data_ready;
    logic                  hs;
    logic                  last;

    assign data_ready = (state == ACCUM);
    assign hs         = bus.data_valid_i & data_ready;
    assign last       = (idx == CNT_W'(IN_COUNT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start_i)              state_nxt = ACCUM;
            ACCUM:   if (hs && last)               state_nxt = OUTPUT;
            OUTPUT:  if (bus.result_ready_i)       state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    // Index wraps to 0 on the final handshake so the address is already parked for the next pass.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx <= '0;
        end else if (state != ACCUM) begin
            idx <= '0;
        end else if (hs) begin
            idx <= last ? '0 : idx + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            bias_q  <= '0;
        end else if (state == IDLE && bus.start_i) begin
            shift_q <= bus.shift_i;
            bias_q  <= bus.bias_i;
        end
    end

    // Bias seeds the first term, so no separate accumulator clear is needed.
    assign mac_add = (idx == '0) ? bias_q : mac;

    mac_shifter #(.N(N)) u_mac (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (hs),
        .value_i (bus.data_i),
        .mult_i  (bus.weight_i),
        .shift_i (shift_q),
        .add_i   (mac_add),
        .mac_o   (mac)
    );

`ifdef DENSE_SEQ_RELU_EN
    assign out_val = mac[2*N-1] ? '0 : mac;
`else
    assign out_val = mac;
`endif

    assign bus.weight_addr_o  = hs ? idx + CNT_W'(1) : idx;
    assign bus.data_ready_o   = data_ready;
    assign bus.busy_o         = (state != IDLE);
    assign bus.result_valid_o = (state == OUTPUT);
    assign bus.result_o       = (state == OUTPUT) ? out_val : '0;
endmodule

// File: tb/tb_dense_neuron_sequencer.sv
// Directed bench for dense_neuron_sequencer with IN_COUNT=4, N=16 and a 1-cycle ROM model.
module tb_dense_neuron_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic signed [15:0] rom [4];
    logic signed [15:0] dat [4];

    dense_neuron_sequencer_if #(.N(16), .CNT_W(2)) bus ();

    dense_neuron_sequencer #(.N(16), .IN_COUNT(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.weight_i <= rom[bus.weight_addr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] relu(input int v);
`ifdef DENSE_SEQ_RELU_EN
        return (v < 0) ? 32'd0 : 32'(v);
`else
        return 32'(v);
`endif
    endfunction

    task automatic load(input int w0, input int w1, input int w2, input int w3,
                        input int d0, input int d1, input int d2, input int d3);
        rom[0] = 16'(w0); rom[1] = 16'(w1); rom[2] = 16'(w2); rom[3] = 16'(w3);
        dat[0] = 16'(d0); dat[1] = 16'(d1); dat[2] = 16'(d2); dat[3] = 16'(d3);
    endtask

    // Entered and left at posedge+1 in IDLE.
    task automatic do_pass(input int bias, input int sh, input bit gaps, input int hold,
                           input bit poke, input logic [31:0] exp);
        logic [7:0] gap_pat;
        logic [1:0] exp_addr;
        int k;
        int cyc;
        gap_pat = 8'b1011_0010;
        bus.start_i = 1'b1;
        bus.bias_i  = 32'(bias);
        bus.shift_i = 6'(sh);
        #1;
        chk("idle_addr", 32'(bus.weight_addr_o), 32'd0);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        chk("accum_busy", 32'(bus.busy_o), 32'd1);
        chk("accum_ready", 32'(bus.data_ready_o), 32'd1);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            bus.data_valid_i = !(gaps && gap_pat[cyc % 8]);
            bus.data_i = dat[k];
            if (poke && cyc == 1) begin
                bus.start_i = 1'b1;
                bus.bias_i  = 32'sd1000;
                bus.shift_i = 6'd3;
            end else begin
                bus.start_i = 1'b0;
            end
            #1;
            exp_addr = bus.data_valid_i ? 2'(k + 1) : 2'(k);
            chk("addr", 32'(bus.weight_addr_o), 32'(exp_addr));
            chk("accum_rvalid", 32'(bus.result_valid_o), 32'd0);
            @(posedge clk); #1;
            if (bus.data_valid_i) k++;
            cyc++;
        end
        bus.start_i = 1'b0;
        bus.data_valid_i = 1'b0;
        chk("hs_count", 32'(k), 32'd4);
        if (!gaps) chk("latency", 32'(cyc), 32'd4);
        chk("rvalid", 32'(bus.result_valid_o), 32'd1);
        chk("result", bus.result_o, exp);
        chk("out_ready", 32'(bus.data_ready_o), 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus.data_valid_i = 1'b1;
            @(posedge clk); #1;
            chk("hold_result", bus.result_o, exp);
            chk("hold_ready", 32'(bus.data_ready_o), 32'd0);
        end
        bus.data_valid_i = 1'b0;
        bus.result_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.result_ready_i = 1'b0;
        chk("done_busy", 32'(bus.busy_o), 32'd0);
        chk("done_rvalid", 32'(bus.result_valid_o), 32'd0);
        chk("done_result", bus.result_o, 32'd0);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.shift_i = '0;
        bus.bias_i = '0;
        bus.data_i = '0;
        bus.data_valid_i = 1'b0;
        bus.result_ready_i = 1'b0;
        load(1, 2, 3, 4, 5, 6, 7, 8);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_ready", 32'(bus.data_ready_o), 32'd0);
        chk("rst_rvalid", 32'(bus.result_valid_o), 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_addr", 32'(bus.weight_addr_o), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 10 + 5 + 12 + 21 + 32
        do_pass(10, 0, 1'b0, 0, 1'b0, 32'd80);

        load(4, 4, 4, 4, 1, 1, 1, 1);
        do_pass(0, 2, 1'b0, 0, 1'b0, 32'd4);

        // -4 >>> 2 = -1 per term
        load(-4, -4, -4, -4, 1, 1, 1, 1);
        do_pass(0, 2, 1'b0, 0, 1'b0, relu(-4));

        load(1, 2, 3, 4, 5, 6, 7, 8);
        do_pass(10, 0, 1'b1, 10, 1'b0, 32'd80);
        do_pass(10, 0, 1'b0, 0, 1'b1, 32'd80);

        // Abort mid-ACCUM
        bus.start_i = 1'b1;
        bus.bias_i = 32'sd10;
        bus.shift_i = 6'd0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.data_valid_i = 1'b1;
        bus.data_i = dat[0];
        @(posedge clk); #1;
        bus.data_i = dat[1];
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy_o), 32'd0);
        chk("abort_ready", 32'(bus.data_ready_o), 32'd0);
        chk("abort_rvalid", 32'(bus.result_valid_o), 32'd0);
        chk("abort_result", bus.result_o, 32'd0);
        chk("abort_addr", 32'(bus.weight_addr_o), 32'd0);
        bus.data_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_pass(10, 0, 1'b0, 0, 1'b0, 32'd80);

        load(-1, -1, -1, -1, 10, 10, 10, 10);
        do_pass(0, 0, 1'b0, 0, 1'b0, relu(-40));

        // 6, -12, -7, 5 shifted by 1 -> 3, -6, -4, 2; plus bias -6
        load(2, -3, 1, 5, 3, 4, -7, 1);
        do_pass(-6, 1, 1'b1, 2, 1'b0, relu(-11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
